// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the pipeline: stat codes, icodes, ALU
// functions, branch/move conditions, register constants and the values
// loaded into a pipeline register on a bubble.
package y86_pkg;

  localparam int DEF_WORD_W = 64;

  typedef enum logic [2:0] {
    SBUB = 3'd0, SAOK = 3'd1, SHLT = 3'd2, SADR = 3'd3, SINS = 3'd4
  } stat_t;

  typedef enum logic [3:0] {
    I_HALT = 4'h0, I_NOP = 4'h1, I_RRMOV = 4'h2, I_IRMOV = 4'h3,
    I_RMMOV = 4'h4, I_MRMOV = 4'h5, I_OPQ = 4'h6, I_JXX = 4'h7,
    I_CALL = 4'h8, I_RET = 4'h9, I_PUSH = 4'hA, I_POP = 4'hB
  } icode_t;

  typedef enum logic [3:0] {
    A_ADD = 4'h0, A_SUB = 4'h1, A_AND = 4'h2, A_XOR = 4'h3
  } alufun_t;

  typedef enum logic [3:0] {
    C_YES = 4'h0, C_LE = 4'h1, C_L = 4'h2, C_E = 4'h3,
    C_NE = 4'h4, C_GE = 4'h5, C_G = 4'h6
  } cond_t;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RSP   = 4'h4;

  // Bubble contents: a NOP with no destinations.
  localparam logic [2:0] BUB_STAT  = SBUB;
  localparam logic [3:0] BUB_ICODE = I_NOP;
  localparam logic [3:0] BUB_IFUN  = 4'h0;

  // CC packed as {ZF,SF,OF}.
  localparam logic [2:0] CC_RESET = 3'b100;

  // An exception further down the pipe freezes the condition codes.
  function automatic logic stat_exc(input logic [2:0] s);
    return (s == SADR) || (s == SINS) || (s == SHLT);
  endfunction

  function automatic logic cond_eval(input logic [3:0] ifun, input logic [2:0] cc);
    logic zf, sf, of;
    {zf, sf, of} = cc;
    case (ifun)
      C_YES:   return 1'b1;
      C_LE:    return (sf ^ of) | zf;
      C_L:     return sf ^ of;
      C_E:     return zf;
      C_NE:    return ~zf;
      C_GE:    return ~(sf ^ of);
      C_G:     return ~(sf ^ of) & ~zf;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/execute_stage_if.sv
// Decode-to-execute bus: D-side register inputs, downstream stat gating,
// and the E-register / ALU results going to M and the forwarding paths.
//   master: decode/pipeline control side (drives D_*, d_*, stats, bubble)
//   slave : execute stage (drives E_*, e_*)
interface execute_stage_if #(parameter int WORD_W = 64);
  logic              E_bubble;
  logic [2:0]        D_stat;
  logic [3:0]        D_icode, D_ifun;
  logic [WORD_W-1:0] D_valC, d_valA, d_valB;
  logic [3:0]        d_dstE, d_dstM, d_srcA, d_srcB;
  logic [2:0]        m_stat, W_stat;

  logic [2:0]        E_stat;
  logic [3:0]        E_icode;
  logic [WORD_W-1:0] E_valA;
  logic [3:0]        E_dstM, E_srcA, E_srcB;
  logic [WORD_W-1:0] e_valE;
  logic              e_Cnd;
  logic [3:0]        e_dstE;

  modport master (
    output E_bubble, D_stat, D_icode, D_ifun, D_valC, d_valA, d_valB,
           d_dstE, d_dstM, d_srcA, d_srcB, m_stat, W_stat,
    input  E_stat, E_icode, E_valA, E_dstM, E_srcA, E_srcB, e_valE, e_Cnd, e_dstE
  );

  modport slave (
    input  E_bubble, D_stat, D_icode, D_ifun, D_valC, d_valA, d_valB,
           d_dstE, d_dstM, d_srcA, d_srcB, m_stat, W_stat,
    output E_stat, E_icode, E_valA, E_dstM, E_srcA, E_srcB, e_valE, e_Cnd, e_dstE
  );
endinterface

// File: rtl/y86_alu.sv
// Combinational Y86-64 ALU.
//   alu_a, alu_b : operands (result is B op A)
//   alufun       : ADD/SUB/AND/XOR, anything else yields 0
//   val_e        : result, modulo 2^WORD_W
//   zf, sf, of   : zero, sign, signed overflow (OF only for ADD/SUB)
module y86_alu import y86_pkg::*; #(
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic [WORD_W-1:0] alu_a,
  input  logic [WORD_W-1:0] alu_b,
  input  logic [3:0]        alufun,
  output logic [WORD_W-1:0] val_e,
  output logic              zf,
  output logic              sf,
  output logic              of
);
  localparam int M = WORD_W - 1;

  always_comb begin
    val_e = '0;
    of    = 1'b0;
    case (alufun)
      A_ADD: begin
        val_e = alu_b + alu_a;
        of    = (alu_a[M] == alu_b[M]) && (val_e[M] != alu_a[M]);
      end
      A_SUB: begin
        val_e = alu_b - alu_a;
        of    = (alu_a[M] != alu_b[M]) && (val_e[M] != alu_b[M]);
      end
      A_AND:   val_e = alu_b & alu_a;
      A_XOR:   val_e = alu_b ^ alu_a;
      default: val_e = '0;
    endcase
  end

  assign zf = (val_e == '0);
  assign sf = val_e[M];
endmodule

// File: rtl/execute_stage.sv
// Y86-64 Execute stage: E pipeline register, operand selection, ALU,
// condition-code register and Cnd logic.
//   clk, reset : single clock, synchronous active-high reset
//   io (slave) : D-side inputs, m/W stat for CC gating, E register and
//                e_valE / e_Cnd / e_dstE outputs
module execute_stage import y86_pkg::*; #(
  parameter int WORD_W = DEF_WORD_W
) (
  input logic           clk,
  input logic           reset,
  execute_stage_if.slave io
);
  typedef struct packed {
    logic [2:0]        stat;
    logic [3:0]        icode;
    logic [3:0]        ifun;
    logic [WORD_W-1:0] valC;
    logic [WORD_W-1:0] valA;
    logic [WORD_W-1:0] valB;
    logic [3:0]        dstE;
    logic [3:0]        dstM;
    logic [3:0]        srcA;
    logic [3:0]        srcB;
  } ereg_t;

  localparam ereg_t E_BUBBLE = '{stat: BUB_STAT, icode: BUB_ICODE, ifun: BUB_IFUN,
                                 valC: '0, valA: '0, valB: '0,
                                 dstE: RNONE, dstM: RNONE, srcA: RNONE, srcB: RNONE};
  localparam logic [WORD_W-1:0] EIGHT = WORD_W'(8);

  ereg_t             e_q, e_d;
  logic [2:0]        cc_q, cc_d;
  logic [WORD_W-1:0] alu_a, alu_b, val_e;
  logic [3:0]        alufun;
  logic              zf, sf, of, set_cc, cnd;

  // E register next value: bubble or capture decode.
  always_comb begin
    e_d = '{stat: io.D_stat, icode: io.D_icode, ifun: io.D_ifun,
            valC: io.D_valC, valA: io.d_valA, valB: io.d_valB,
            dstE: io.d_dstE, dstM: io.d_dstM, srcA: io.d_srcA, srcB: io.d_srcB};
    if (io.E_bubble) e_d = E_BUBBLE;
  end

  always_comb begin
    case (e_q.icode)
      I_RRMOV, I_OPQ:           alu_a = e_q.valA;
      I_IRMOV, I_RMMOV, I_MRMOV: alu_a = e_q.valC;
      I_CALL, I_PUSH:           alu_a = -EIGHT;
      I_RET, I_POP:             alu_a = EIGHT;
      default:                  alu_a = '0;
    endcase
    case (e_q.icode)
      I_RMMOV, I_MRMOV, I_OPQ, I_CALL, I_RET, I_PUSH, I_POP: alu_b = e_q.valB;
      default:                                               alu_b = '0;
    endcase
    alufun = (e_q.icode == I_OPQ) ? e_q.ifun : A_ADD;
  end

  y86_alu #(.WORD_W(WORD_W)) u_alu (
    .alu_a (alu_a),
    .alu_b (alu_b),
    .alufun(alufun),
    .val_e (val_e),
    .zf    (zf),
    .sf    (sf),
    .of    (of)
  );

  // CC follows whatever sits in E now; a bubble arriving this edge does not
  // cancel the update of the instruction leaving E.
  assign set_cc = (e_q.icode == I_OPQ) && !stat_exc(io.m_stat) && !stat_exc(io.W_stat);

  always_comb begin
    cc_d = cc_q;
    if (set_cc) cc_d = {zf, sf, of};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q  <= E_BUBBLE;
      cc_q <= CC_RESET;
    end else begin
      e_q  <= e_d;
      cc_q <= cc_d;
    end
  end

  // Condition uses the pre-update CC.
  assign cnd = cond_eval(e_q.ifun, cc_q);

  assign io.E_stat  = e_q.stat;
  assign io.E_icode = e_q.icode;
  assign io.E_valA  = e_q.valA;
  assign io.E_dstM  = e_q.dstM;
  assign io.E_srcA  = e_q.srcA;
  assign io.E_srcB  = e_q.srcB;
  assign io.e_valE  = val_e;
  assign io.e_Cnd   = cnd;
  // A not-taken cmov writes nowhere.
  assign io.e_dstE  = ((e_q.icode == I_RRMOV) && !cnd) ? RNONE : e_q.dstE;
endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;
  import y86_pkg::*;

  localparam logic [63:0] M1  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] FE  = 64'hFFFF_FFFF_FFFF_FFFE;
  localparam logic [63:0] MAX = 64'h7FFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  execute_stage_if #(.WORD_W(64)) bus ();

  execute_stage #(.WORD_W(64)) dut (
    .clk  (clk),
    .reset(reset),
    .io   (bus)
  );

  typedef struct {
    string       name;
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [63:0] valE;
    logic        cnd;
    logic [3:0]  dstE;
    logic [63:0] valA;
    logic [2:0]  cc;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string n, input string f, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s got=%h expected=%h", n, f, act, exp);
    end
  endtask

  // Monitor: each negedge after an edge that consumed a stimulus vector.
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk(e.name, "E_stat",  64'(bus.E_stat),  64'(e.stat));
      chk(e.name, "E_icode", 64'(bus.E_icode), 64'(e.icode));
      chk(e.name, "e_valE",  bus.e_valE,       e.valE);
      chk(e.name, "e_Cnd",   64'(bus.e_Cnd),   64'(e.cnd));
      chk(e.name, "e_dstE",  64'(bus.e_dstE),  64'(e.dstE));
      chk(e.name, "E_valA",  bus.E_valA,       e.valA);
      chk(e.name, "cc",      64'(dut.cc_q),    64'(e.cc));
    end
  end

  // Drive one vector (applied at the next posedge) and queue the state
  // expected after that edge.
  task automatic issue(input string nm, input logic r, input logic b,
                       input logic [3:0] ic, input logic [3:0] fn,
                       input logic [63:0] vc, input logic [63:0] va, input logic [63:0] vb,
                       input logic [3:0] de, input logic [2:0] ms,
                       input logic [2:0] xs, input logic [3:0] xi, input logic [63:0] xv,
                       input logic xc, input logic [3:0] xd, input logic [63:0] xa,
                       input logic [2:0] xcc);
    exp_t e;
    @(negedge clk);
    #1;
    reset        = r;
    bus.E_bubble = b;
    bus.D_stat   = SAOK;
    bus.D_icode  = ic;
    bus.D_ifun   = fn;
    bus.D_valC   = vc;
    bus.d_valA   = va;
    bus.d_valB   = vb;
    bus.d_dstE   = de;
    bus.d_dstM   = RNONE;
    bus.d_srcA   = RNONE;
    bus.d_srcB   = RNONE;
    bus.m_stat   = ms;
    bus.W_stat   = SAOK;
    e = '{name: nm, stat: xs, icode: xi, valE: xv, cnd: xc, dstE: xd, valA: xa, cc: xcc};
    sbq.push_back(e);
  endtask

  initial begin
    bus.E_bubble = 1'b0; bus.D_stat = SAOK; bus.D_icode = 4'h1; bus.D_ifun = 4'h0;
    bus.D_valC = '0; bus.d_valA = '0; bus.d_valB = '0; bus.d_dstE = RNONE;
    bus.d_dstM = RNONE; bus.d_srcA = RNONE; bus.d_srcB = RNONE;
    bus.m_stat = SAOK; bus.W_stat = SAOK;

    //     name      rst bub ic    fn    valC  valA    valB    dstE  m_stat  | stat icode valE    cnd dstE  valA   cc
    issue("reset0",   1, 0, 4'h6, 4'h0, 64'h0, 64'h3,  64'h4,  4'h2, SAOK,  3'd0, 4'h1, 64'h0,   1, 4'hF, 64'h0, 3'b100);
    issue("reset1",   1, 0, 4'h6, 4'h0, 64'h0, 64'h3,  64'h4,  4'h2, SAOK,  3'd0, 4'h1, 64'h0,   1, 4'hF, 64'h0, 3'b100);
    issue("opq_sub",  0, 0, 4'h6, 4'h1, 64'h0, 64'h5,  64'h3,  4'h2, SAOK,  3'd1, 4'h6, FE,      1, 4'h2, 64'h5, 3'b100);
    issue("opq_addov",0, 0, 4'h6, 4'h0, 64'h0, MAX,    MAX,    4'h4, SAOK,  3'd1, 4'h6, FE,      1, 4'h4, MAX,   3'b010);
    issue("cmovl_nt", 0, 0, 4'h2, 4'h2, 64'h0, 64'h11, 64'h0,  4'h3, SAOK,  3'd1, 4'h2, 64'h11,  0, 4'hF, 64'h11,3'b011);
    issue("cmovge_t", 0, 0, 4'h2, 4'h5, 64'h0, 64'h22, 64'h0,  4'h6, SAOK,  3'd1, 4'h2, 64'h22,  1, 4'h6, 64'h22,3'b011);
    issue("opq_and",  0, 0, 4'h6, 4'h2, 64'h0, M1,     M1,     4'h5, SAOK,  3'd1, 4'h6, M1,      0, 4'h5, M1,    3'b011);
    issue("madr_hold",0, 0, 4'h1, 4'h0, 64'h0, 64'h0,  64'h0,  4'hF, SADR,  3'd1, 4'h1, 64'h0,   1, 4'hF, 64'h0, 3'b011);
    issue("opq_and2", 0, 0, 4'h6, 4'h2, 64'h0, M1,     M1,     4'h5, SAOK,  3'd1, 4'h6, M1,      0, 4'h5, M1,    3'b011);
    issue("bubble_cc",0, 1, 4'h6, 4'h0, 64'h0, 64'h1,  64'h1,  4'h2, SAOK,  3'd0, 4'h1, 64'h0,   1, 4'hF, 64'h0, 3'b010);
    issue("push",     0, 0, 4'hA, 4'h0, 64'h0, 64'h0,  64'h100,4'h4, SAOK,  3'd1, 4'hA, 64'hF8,  1, 4'h4, 64'h0, 3'b010);
    issue("pop",      0, 0, 4'hB, 4'h0, 64'h0, 64'h0,  64'hF8, 4'h4, SAOK,  3'd1, 4'hB, 64'h100, 1, 4'h4, 64'h0, 3'b010);
    issue("mrmov",    0, 0, 4'h5, 4'h0, 64'h8, 64'h0,  64'h20, 4'hF, SAOK,  3'd1, 4'h5, 64'h28,  1, 4'hF, 64'h0, 3'b010);
    issue("opq_add2", 0, 0, 4'h6, 4'h0, 64'h0, 64'h1,  64'h1,  4'h2, SAOK,  3'd1, 4'h6, 64'h2,   1, 4'h2, 64'h1, 3'b010);
    issue("rst_mid",  1, 0, 4'h6, 4'h0, 64'h0, 64'h1,  M1,     4'h2, SAOK,  3'd0, 4'h1, 64'h0,   1, 4'hF, 64'h0, 3'b100);
    issue("add_zero", 0, 0, 4'h6, 4'h0, 64'h0, 64'h1,  M1,     4'h2, SAOK,  3'd1, 4'h6, 64'h0,   1, 4'h2, 64'h1, 3'b100);
    issue("je_taken", 0, 0, 4'h7, 4'h3, 64'h0, 64'h0,  64'h0,  4'hF, SAOK,  3'd1, 4'h7, 64'h0,   1, 4'hF, 64'h0, 3'b100);
    issue("jne_nt",   0, 0, 4'h7, 4'h4, 64'h0, 64'h0,  64'h0,  4'hF, SAOK,  3'd1, 4'h7, 64'h0,   0, 4'hF, 64'h0, 3'b100);

    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
    #2;
    if (sbq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d expected=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
